cacheline_adaptor: RTL and testbench

//  Bridges the cache's 256-bit line port (pmem_*) to the 64-bit burst physical memory.

---
 rtl/cache_types.sv | 21 ++
 rtl/cacheline_adaptor_if.sv | 29 ++
 rtl/cacheline_adaptor.sv | 123 ++++++++++++
 tb/tb_cacheline_adaptor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types.sv
// Shared cache/memory geometry and the line adaptor's state encoding.
// The cache and the adaptor both import these constants so line and beat widths always agree.
package cache_types;

  localparam int LINE_W    = 256;
  localparam int BURST_W   = 64;
  localparam int BURST_LEN = 4;
  localparam int OFFSET_W  = 5;
  localparam int CNT_W     = $clog2(BURST_LEN);

  // Clears the byte-offset bits so memory always sees a line-aligned address.
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side line port plus memory-side burst port of the line adaptor.
// The slave view belongs to the adaptor; the master view belongs to the cache/memory environment.
interface cacheline_adaptor_if;
  import cache_types::*;

  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache line transfer into four 64-bit memory beats; request to read_o/write_o is one cycle,
// resp_o follows the last beat by one cycle; memory throttles beats with resp_i, cache requests are held until resp_o.
module cacheline_adaptor
  import cache_types::*;
(
  input  logic                clk,
  input  logic                rst,
  cacheline_adaptor_if.slave  bus
);

  if (LINE_W != BURST_W * BURST_LEN) begin : g_geometry_check
    $error("cacheline_adaptor: LINE_W must equal BURST_W*BURST_LEN");
  end

  adaptor_state_t     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nx;
  logic [LINE_W-1:0]  wline_q, wline_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [31:0]        addr_q, addr_d;
  logic               read_q, read_d;
  logic               write_q, write_d;
  logic               resp_q, resp_d;
  logic               last_beat;

  assign cnt_nx    = cnt_q + 1'b1;
  assign last_beat = (cnt_q == CNT_W'(BURST_LEN - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wline_d = wline_q;
    line_d  = line_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    read_d  = read_q;
    write_d = write_q;
    resp_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Read has priority; a simultaneous write is simply not taken.
        if (bus.read_i) begin
          addr_d  = bus.address_i & ADDR_MASK;
          read_d  = 1'b1;
          state_d = RD;
        end else if (bus.write_i) begin
          addr_d  = bus.address_i & ADDR_MASK;
          wline_d = bus.line_i;
          burst_d = bus.line_i[BURST_W-1:0];
          write_d = 1'b1;
          state_d = WR;
        end
      end

      RD: begin
        if (bus.resp_i) begin
          line_d[cnt_q*BURST_W +: BURST_W] = bus.burst_i;
          if (last_beat) begin
            read_d  = 1'b0;
            resp_d  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_nx;
          end
        end
      end

      WR: begin
        if (bus.resp_i) begin
          if (last_beat) begin
            write_d = 1'b0;
            resp_d  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_nx;
            burst_d = wline_q[cnt_nx*BURST_W +: BURST_W];
          end
        end
      end

      DONE: begin
        // resp_o is high for this single cycle; the cache drops its request next cycle.
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wline_q <= '0;
      line_q  <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wline_q <= wline_d;
      line_q  <= line_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign bus.line_o    = line_q;
  assign bus.burst_o   = burst_q;
  assign bus.address_o = addr_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: stimulus queues expected completions and write beats,
// a negedge monitor pops and compares whenever the adaptor presents resp_o or an accepted write beat.
module tb_cacheline_adaptor;
  import cache_types::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_adaptor_if bus();

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0]       addr;
    logic              is_read;
    logic [LINE_W-1:0] line;
  } exp_resp_t;

  exp_resp_t          resp_q[$];
  logic [BURST_W-1:0] beat_q[$];
  int checks   = 0;
  int failures = 0;

  localparam logic [BURST_W-1:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event with nothing expected", name);
  endtask

  // Monitor: compares completions and accepted write beats against the queues.
  initial begin
    exp_resp_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.resp_o) begin
        if (resp_q.size() == 0) flag("unexpected_resp_o");
        else begin
          e = resp_q.pop_front();
          chk("resp_addr", bus.address_o, e.addr);
          if (e.is_read) chk("resp_line", bus.line_o, e.line);
        end
      end
      if (rst && bus.write_o && bus.resp_i) begin
        if (beat_q.size() == 0) flag("unexpected_wr_beat");
        else chk("wr_beat", bus.burst_o, beat_q.pop_front());
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [LINE_W-1:0] exp_line, input logic [BURST_W-1:0] beats [BURST_LEN],
                         input string pattern, input logic with_write, input logic done_pulse);
    int n;
    int k;
    resp_q.push_back('{addr: exp_addr, is_read: 1'b1, line: exp_line});
    bus.address_i = addr;
    bus.read_i    = 1'b1;
    bus.write_i   = with_write;
    bus.line_i    = {4{64'h5A5A_5A5A_5A5A_5A5A}};
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.read_o && n < 20);
    chk("rd_req_lat", n, 1);
    chk("rd_no_write_o", bus.write_o, 0);
    k = 0;
    for (int i = 0; i < pattern.len(); i++) begin
      bus.resp_i  = (pattern[i] == "1");
      bus.burst_i = bus.resp_i ? beats[k] : JUNK;
      if (bus.resp_i) k++;
      @(posedge clk); #1;
    end
    bus.resp_i  = done_pulse;
    bus.burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    n = 0;
    while (!bus.resp_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rd_resp_lat", n, 0);
    chk("rd_read_o_drop", bus.read_o, 0);
    @(posedge clk); #1;
    bus.resp_i  = 1'b0;
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    chk("rd_resp_one_cycle", bus.resp_o, 0);
    chk("rd_line_hold", bus.line_o, exp_line);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [LINE_W-1:0] line, input logic [BURST_W-1:0] exp_beats [BURST_LEN],
                          input string pattern);
    int n;
    resp_q.push_back('{addr: exp_addr, is_read: 1'b0, line: '0});
    for (int i = 0; i < BURST_LEN; i++) beat_q.push_back(exp_beats[i]);
    bus.address_i = addr;
    bus.line_i    = line;
    bus.write_i   = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.write_o && n < 20);
    chk("wr_req_lat", n, 1);
    chk("wr_no_read_o", bus.read_o, 0);
    for (int i = 0; i < pattern.len(); i++) begin
      bus.resp_i  = (pattern[i] == "1");
      bus.burst_i = JUNK;
      @(posedge clk); #1;
    end
    bus.resp_i = 1'b0;
    n = 0;
    while (!bus.resp_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wr_resp_lat", n, 0);
    chk("wr_write_o_drop", bus.write_o, 0);
    @(posedge clk); #1;
    bus.write_i = 1'b0;
    chk("wr_resp_one_cycle", bus.resp_o, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_line_o"},    bus.line_o,    0);
    chk({tag, "_burst_o"},   bus.burst_o,   0);
    chk({tag, "_address_o"}, bus.address_o, 0);
    chk({tag, "_read_o"},    bus.read_o,    0);
    chk({tag, "_write_o"},   bus.write_o,   0);
    chk({tag, "_resp_o"},    bus.resp_o,    0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [BURST_W-1:0] b [BURST_LEN];
    logic [BURST_W-1:0] wb [BURST_LEN];

    rst           = 1'b0;
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: aligned read, back-to-back beats
    b = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
          64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    do_read(32'h0000_1234, 32'h0000_1220,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
            b, "1111", 1'b0, 1'b0);

    // 2: write split into four beats, low beat first
    wb = '{64'h0000_0000_0000_BEEF, 64'hF00D_0001_1111_1111,
           64'hCAFE_0002_2222_2222, 64'hDEAD_0003_3333_3333};
    do_write(32'h0000_0040, 32'h0000_0040,
             {64'hDEAD_0003_3333_3333, 64'hCAFE_0002_2222_2222,
              64'hF00D_0001_1111_1111, 64'h0000_0000_0000_BEEF},
             wb, "1111");

    // 3: read with gaps between beats
    b = '{64'hA0A0_0000_0000_0001, 64'hA0A0_0000_0000_0002,
          64'hA0A0_0000_0000_0003, 64'hA0A0_0000_0000_0004};
    do_read(32'h0000_ABCD, 32'h0000_ABC0,
            {64'hA0A0_0000_0000_0004, 64'hA0A0_0000_0000_0003,
             64'hA0A0_0000_0000_0002, 64'hA0A0_0000_0000_0001},
            b, "1001101", 1'b0, 1'b0);

    // 4: read and write together, read wins
    b = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
          64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0};
    do_read(32'h8000_007F, 32'h8000_0060,
            {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
             64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
            b, "1111", 1'b1, 1'b0);

    // 5: reset after the second write beat aborts with no completion
    beat_q.push_back(64'h5555_0000_0000_0000);
    beat_q.push_back(64'h5555_0000_0000_0001);
    bus.address_i = 32'h0000_0100;
    bus.line_i    = {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
                     64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};
    bus.write_i   = 1'b1;
    @(posedge clk); #1;
    chk("t5_write_o", bus.write_o, 1);
    bus.resp_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.resp_i  = 1'b0;
    bus.write_i = 1'b0;
    rst         = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("midreset");
    rst = 1'b1;
    @(posedge clk); #1;
    b = '{64'hC1C1_C1C1_C1C1_C1C1, 64'hC2C2_C2C2_C2C2_C2C2,
          64'hC3C3_C3C3_C3C3_C3C3, 64'hC4C4_C4C4_C4C4_C4C4};
    do_read(32'h0000_1FFF, 32'h0000_1FE0,
            {64'hC4C4_C4C4_C4C4_C4C4, 64'hC3C3_C3C3_C3C3_C3C3,
             64'hC2C2_C2C2_C2C2_C2C2, 64'hC1C1_C1C1_C1C1_C1C1},
            b, "1111", 1'b0, 1'b0);

    // 6: resp_i pulses in IDLE and DONE are ignored
    bus.resp_i  = 1'b1;
    bus.burst_i = JUNK;
    repeat (2) @(posedge clk);
    #1;
    bus.resp_i = 1'b0;
    chk("idle_pulse_read_o",  bus.read_o,  0);
    chk("idle_pulse_write_o", bus.write_o, 0);
    chk("idle_pulse_resp_o",  bus.resp_o,  0);
    chk("idle_pulse_line_o",  bus.line_o,
        {64'hC4C4_C4C4_C4C4_C4C4, 64'hC3C3_C3C3_C3C3_C3C3,
         64'hC2C2_C2C2_C2C2_C2C2, 64'hC1C1_C1C1_C1C1_C1C1});
    b = '{64'h0000_0000_0000_00E1, 64'h0000_0000_0000_00E2,
          64'h0000_0000_0000_00E3, 64'h0000_0000_0000_00E4};
    do_read(32'hFFFF_FFFF, 32'hFFFF_FFE0,
            {64'h0000_0000_0000_00E4, 64'h0000_0000_0000_00E3,
             64'h0000_0000_0000_00E2, 64'h0000_0000_0000_00E1},
            b, "0110011", 1'b0, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    chk("resp_q_drained", resp_q.size(), 0);
    chk("beat_q_drained", beat_q.size(), 0);
    chk("final_resp_o", bus.resp_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
